// File: rtl/sig_reg_writer.sv
// Serial command receiver feeding a timed register-write sequencer for the signal generator.
// Optional shadow RAM of written registers is enabled by defining SIG_REG_WRITER_SHADOW_EN.
module sig_reg_writer #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 1,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  input  logic       clr_flags,
  output logic       write_strobe,
  output logic [2:0] address,
  output logic [4:0] data,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow,
  output logic       frame_err
`ifdef SIG_REG_WRITER_SHADOW_EN
  ,
  input  logic [2:0] shadow_addr,
  output logic [4:0] shadow_data
`endif
);

  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StGap} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic sclk_s, mosi_s, cs_s, sclk_prev_q, cs_prev_q;
  logic sclk_rise, cs_fall, cs_rise;

  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] frame_q;
  logic       push_q;
  logic       overflow_q, frame_err_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, avail, pop_slot, pop, mem_rd, mem_wr, bypass, ovf_set;
  logic [7:0]    head;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          strobe_q;
  logic [2:0]    addr_q;
  logic [4:0]    data_q;

  // cs_n idles high so reset never fabricates a frame-select edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      frame_q   <= '0;
      push_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (cs_fall || cs_rise) begin
        bit_cnt_q <= '0;
      end else if (!cs_s && sclk_rise) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          frame_q <= {shift_q, mosi_s};
          push_q  <= 1'b1;
        end
      end
    end
  end

  // An empty FIFO lets a fresh frame go straight to the output registers
  assign full    = (count_q == FULL_COUNT);
  assign avail   = (count_q != '0) | push_q;
  assign head    = (count_q != '0) ? mem_q[rd_ptr_q] : frame_q;
  assign pop     = pop_slot & avail;
  assign mem_rd  = pop & (count_q != '0);
  assign bypass  = pop & (count_q == '0);
  assign mem_wr  = push_q & ~bypass & (~full | mem_rd);
  assign ovf_set = push_q & full & ~mem_rd;

  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[wr_ptr_q] <= frame_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (mem_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (mem_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW + 1)'(mem_wr) - (AW + 1)'(mem_rd);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (ovf_set) overflow_q <= 1'b1;
      else if (clr_flags) overflow_q <= 1'b0;
      if (cs_rise && (bit_cnt_q != 3'd0)) frame_err_q <= 1'b1;
      else if (clr_flags) frame_err_q <= 1'b0;
    end
  end

  // The last HOLD/GAP cycle may pop directly, keeping the write period free of an IDLE cycle
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    pop_slot = 1'b0;
    case (state_q)
      StIdle: begin
        pop_slot = 1'b1;
        if (avail) state_d = StSetup;
      end
      StSetup: begin
        state_d = StStrobe;
        cyc_d   = '0;
      end
      StStrobe: begin
        if (cyc_q == STROBE_LAST) state_d = StHold;
        else cyc_d = cyc_q + CW'(1);
      end
      StHold: begin
        if (GAP_CYCLES == 0) begin
          pop_slot = 1'b1;
          state_d  = avail ? StSetup : StIdle;
        end else begin
          state_d = StGap;
          cyc_d   = '0;
        end
      end
      StGap: begin
        if (cyc_q == GAP_LAST) begin
          pop_slot = 1'b1;
          state_d  = avail ? StSetup : StIdle;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cyc_q    <= '0;
      strobe_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      strobe_q <= (state_d == StStrobe);
      if (pop) {data_q, addr_q} <= head;
    end
  end

  assign write_strobe = strobe_q;
  assign address      = addr_q;
  assign data         = data_q;
  assign busy         = (state_q != StIdle) | (count_q != '0);
  assign fifo_full    = full;
  assign overflow     = overflow_q;
  assign frame_err    = frame_err_q;

`ifdef SIG_REG_WRITER_SHADOW_EN
  logic [4:0] shadow_q [8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
    end else if (state_q == StStrobe && cyc_q == '0) begin
      shadow_q[addr_q] <= data_q;
    end
  end

  assign shadow_data = shadow_q[shadow_addr];
`endif

endmodule

// File: tb/tb_sig_reg_writer.sv
// Self-checking bench: random and directed serial frames against a frame-order reference model.
// Instance b uses a very long strobe so its FIFO backs up and overflows.
module tb_sig_reg_writer;

  logic clk = 1'b0;
  logic rst, sclk, mosi, cs_n_a, cs_n_b, clr_flags;
  logic a_strobe, a_busy, a_full, a_ovf, a_ferr;
  logic b_strobe, b_busy, b_full, b_ovf, b_ferr;
  logic [2:0] a_addr, b_addr;
  logic [4:0] a_data, b_data;
`ifdef SIG_REG_WRITER_SHADOW_EN
  logic [2:0] a_saddr, b_saddr;
  logic [4:0] a_sdata, b_sdata;
`endif

  int total = 0;
  int bad = 0;
  bit sel_b = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] got_a[$], got_b[$];
  int len_a[$], len_b[$], rise_b[$];
  int setup_bad_a = 0, hold_bad_a = 0, setup_bad_b = 0, hold_bad_b = 0;
  int cyc = 0, run_a = 0, run_b = 0;
  logic sa_q = 1'b0, sb_q = 1'b0;
  logic [7:0] wa_q = '0, wb_q = '0;

  always #5 clk = ~clk;

  sig_reg_writer u_dut_a (
    .clk(clk), .rst(rst), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n_a),
    .clr_flags(clr_flags), .write_strobe(a_strobe), .address(a_addr), .data(a_data),
    .busy(a_busy), .fifo_full(a_full), .overflow(a_ovf), .frame_err(a_ferr)
`ifdef SIG_REG_WRITER_SHADOW_EN
    , .shadow_addr(a_saddr), .shadow_data(a_sdata)
`endif
  );

  sig_reg_writer #(.STROBE_CYCLES(1000)) u_dut_b (
    .clk(clk), .rst(rst), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n_b),
    .clr_flags(clr_flags), .write_strobe(b_strobe), .address(b_addr), .data(b_data),
    .busy(b_busy), .fifo_full(b_full), .overflow(b_ovf), .frame_err(b_ferr)
`ifdef SIG_REG_WRITER_SHADOW_EN
    , .shadow_addr(b_saddr), .shadow_data(b_sdata)
`endif
  );

  // Write monitor: records each write at its strobe rise, strobe length, and setup/hold stability
  always @(negedge clk) begin
    cyc  <= cyc + 1;
    sa_q <= a_strobe;
    wa_q <= {a_data, a_addr};
    sb_q <= b_strobe;
    wb_q <= {b_data, b_addr};
    if (a_strobe && !sa_q) begin
      got_a.push_back({a_data, a_addr});
      run_a <= 1;
      if ({a_data, a_addr} !== wa_q) setup_bad_a <= setup_bad_a + 1;
    end else if (a_strobe) begin
      run_a <= run_a + 1;
    end
    if (!a_strobe && sa_q && !rst) begin
      len_a.push_back(run_a);
      if ({a_data, a_addr} !== wa_q) hold_bad_a <= hold_bad_a + 1;
    end
    if (b_strobe && !sb_q) begin
      got_b.push_back({b_data, b_addr});
      rise_b.push_back(cyc);
      run_b <= 1;
      if ({b_data, b_addr} !== wb_q) setup_bad_b <= setup_bad_b + 1;
    end else if (b_strobe) begin
      run_b <= run_b + 1;
    end
    if (!b_strobe && sb_q && !rst) begin
      len_b.push_back(run_b);
      if ({b_data, b_addr} !== wb_q) hold_bad_b <= hold_bad_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #40;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    if (sel_b) cs_n_b = 1'b0;
    else cs_n_a = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #80;
    if (sel_b) cs_n_b = 1'b1;
    else cs_n_a = 1'b1;
    #80;
  endtask

  task automatic wait_idle(input string tag, input bit use_b, input int max);
    bit ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (!(use_b ? b_busy : a_busy)) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    #1;
  endtask

  // Every sent frame must appear exactly once, in order, with a 2-cycle strobe
  task automatic compare_a(input string tag);
    check({tag, "_count"}, got_a.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++)
      check({tag, "_frame"}, 32'(got_a[i]), 32'(exp_q[i]));
    for (int i = 0; i < len_a.size(); i++) check({tag, "_strobe_len"}, len_a[i], 2);
    check({tag, "_setup_hold"}, setup_bad_a + hold_bad_a, 0);
    got_a.delete();
    len_a.delete();
    exp_q.delete();
  endtask

  task automatic send_burst(input string tag, input logic [7:0] frames[$]);
    cs_low();
    foreach (frames[i]) begin
      send_bits(frames[i], 8);
      exp_q.push_back(frames[i]);
    end
    cs_high();
    wait_idle({tag, "_idle"}, 1'b0, 300);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] fr[$];
    logic [7:0] b_sent[$];
    bit seen;
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n_a = 1'b1; cs_n_b = 1'b1; clr_flags = 1'b0;
`ifdef SIG_REG_WRITER_SHADOW_EN
    a_saddr = '0; b_saddr = '0;
`endif
    #25;
    check("rst_strobe", {a_strobe, b_strobe}, 0);
    check("rst_addr_data", {a_addr, a_data, b_addr, b_data}, 0);
    check("rst_status", {a_busy, a_full, a_ovf, a_ferr, b_busy, b_full, b_ovf, b_ferr}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    fr = '{8'hAD};
    send_burst("single", fr);
    check("single_addr", a_addr, 3'b101);
    check("single_data", a_data, 5'b10101);
    compare_a("single");

    fr = '{8'h11, 8'h22, 8'h33};
    send_burst("burst", fr);
    check("burst_busy", a_busy, 0);
    compare_a("burst");

    for (int r = 0; r < 4; r++) begin
      fr.delete();
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) fr.push_back(8'($urandom));
      send_burst("rand", fr);
      compare_a("rand");
    end
    check("flags_clean", {a_ovf, a_ferr}, 0);

    cs_low();
    cs_high();
    check("empty_cs_no_err", a_ferr, 0);
    cs_low();
    send_bits(8'hB7, 5);
    cs_high();
    check("partial_err", a_ferr, 1);
    repeat (20) @(negedge clk);
    check("partial_no_write", got_a.size(), 0);
    fr = '{8'h08};
    send_burst("after_partial", fr);
    check("after_partial_addr_data", {a_addr, a_data}, {3'd0, 5'd1});
    compare_a("after_partial");
    check("err_sticky", a_ferr, 1);
    pulse_clr();
    check("err_cleared", a_ferr, 0);

    // Instance b: first frame goes straight to the output regs, four queue, the sixth drops
    sel_b = 1'b1;
    cs_low();
    for (int j = 0; j < 6; j++) begin
      b_sent.push_back(8'($urandom));
      send_bits(b_sent[j], 8);
    end
    cs_high();
    check("ovf_full", b_full, 1);
    check("ovf_set", b_ovf, 1);
    check("ovf_a_untouched", a_ovf, 0);
    pulse_clr();
    check("ovf_cleared", b_ovf, 0);
    check("ovf_still_full", b_full, 1);
    wait_idle("ovf_idle", 1'b1, 6000);
    check("ovf_count", got_b.size(), 5);
    for (int i = 0; i < 5 && i < got_b.size(); i++) check("ovf_frame", got_b[i], b_sent[i]);
    for (int i = 1; i < rise_b.size(); i++) check("ovf_period", rise_b[i] - rise_b[i-1], 1003);
    for (int i = 0; i < len_b.size(); i++) check("ovf_strobe_len", len_b[i], 1000);
    check("ovf_setup_hold", setup_bad_b + hold_bad_b, 0);
    sel_b = 1'b0;

    // Reset on the first strobe cycle
    cs_low();
    send_bits(8'h5A, 7);
    mosi = 1'b0;
    #40;
    sclk = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (a_strobe) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid_seen", 32'(seen), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_strobe", a_strobe, 0);
    check("rst_mid_status", {a_busy, a_full, a_addr, a_data}, 0);
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cs_high();
    repeat (100) @(negedge clk);
    check("rst_mid_writes", got_a.size(), 1);
    check("rst_mid_idle", {a_busy, a_strobe, a_addr, a_data}, 0);
    got_a.delete();
    len_a.delete();

`ifdef SIG_REG_WRITER_SHADOW_EN
    begin
      logic [4:0] smodel [8];
      for (int i = 0; i < 8; i++) smodel[i] = '0;
      fr = '{8'hFF, 8'h0F};
      foreach (fr[i]) smodel[fr[i][2:0]] = fr[i][7:3];
      send_burst("shadow", fr);
      compare_a("shadow");
      for (int i = 0; i < 8; i++) begin
        a_saddr = 3'(i);
        b_saddr = 3'(i);
        #1;
        check("shadow_read", a_sdata, smodel[i]);
        check("shadow_b_clear", b_sdata, 0);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
